// File: rtl/pwm_capture_pkg.sv
// Shared constants for the PWM capture block: register map, CTRL/STATUS
// bit positions and the measurement FSM state encoding.
package pwm_capture_pkg;

  localparam logic [3:0] ADDR_CTRL   = 4'h0;
  localparam logic [3:0] ADDR_PERIOD = 4'h4;
  localparam logic [3:0] ADDR_HIGH   = 4'h8;
  localparam logic [3:0] ADDR_STATUS = 4'hC;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_POL    = 1;
  localparam int CTRL_IRQ_EN = 2;

  localparam int ST_VALID   = 0;
  localparam int ST_OVERRUN = 1;
  localparam int ST_TIMEOUT = 2;
  localparam int ST_LEVEL   = 3;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARM       = 2'd1,
    MEAS_HIGH = 2'd2,
    MEAS_LOW  = 2'd3
  } state_t;

endpackage

// File: rtl/pwm_in_sync.sv
// Brings pwm_in into the clk domain and produces polarity-adjusted level
// plus single-cycle rise/fall strobes.
module pwm_in_sync (
  input  logic clk,
  input  logic reset,
  input  logic pwm_in,
  input  logic pol,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic s1, s2, raw_d;
  logic lvl_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      raw_d <= 1'b0;
    end else begin
      s1    <= pwm_in;
      s2    <= s1;
      raw_d <= s2;
    end
  end

  // Delayed level is held before inversion so a POL change never fakes an edge.
  assign lvl   = s2 ^ pol;
  assign lvl_d = raw_d ^ pol;
  assign rise  = lvl & ~lvl_d;
  assign fall  = ~lvl & lvl_d;

endmodule

// File: rtl/pwm_capture_ip.sv
// PWM period / high-time capture with a small register interface:
// FSM + cycle counter, result registers, W1C status and level interrupt.
module pwm_capture_ip
  import pwm_capture_pkg::*;
#(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_sel,
  input  logic        i_we,
  input  logic [3:0]  i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  input  logic        pwm_in,
  output logic        irq
);

  logic        en, pol, irq_en;
  logic        valid, overrun, timeout;
  logic [31:0] period, high, high_tmp, cnt;
  state_t      state, state_n;

  logic [31:0] period_n, high_n, high_tmp_n, cnt_n;
  logic        set_valid, set_overrun, set_timeout;
  logic        lvl, rise, fall;
  logic        wr, ctrl_wr, status_wr, en_eff, pol_chg;
  logic        wdata_unused;

  pwm_in_sync u_sync (
    .clk    (clk),
    .reset  (reset),
    .pwm_in (pwm_in),
    .pol    (pol),
    .lvl    (lvl),
    .rise   (rise),
    .fall   (fall)
  );

  assign wr        = i_sel & i_we;
  assign ctrl_wr   = wr && (i_addr == ADDR_CTRL);
  assign status_wr = wr && (i_addr == ADDR_STATUS);
  // Disable and polarity changes act on the write edge itself.
  assign en_eff    = ctrl_wr ? i_wdata[CTRL_EN] : en;
  assign pol_chg   = ctrl_wr && (i_wdata[CTRL_POL] != pol);
  assign wdata_unused = ^i_wdata[31:3];

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    period_n    = period;
    high_n      = high;
    high_tmp_n  = high_tmp;
    set_valid   = 1'b0;
    set_overrun = 1'b0;
    set_timeout = 1'b0;
    if (!en_eff) begin
      state_n = IDLE;
      cnt_n   = 32'd0;
    end else if (state == IDLE || pol_chg) begin
      state_n = ARM;
      cnt_n   = 32'd0;
    end else if (cnt == TIMEOUT_CYCLES) begin
      set_timeout = 1'b1;
      state_n     = ARM;
      cnt_n       = 32'd0;
    end else begin
      cnt_n = cnt + 32'd1;
      unique case (state)
        ARM: if (rise) begin
          state_n = MEAS_HIGH;
          cnt_n   = 32'd1;
        end
        MEAS_HIGH: if (fall) begin
          state_n    = MEAS_LOW;
          high_tmp_n = cnt;
        end
        MEAS_LOW: if (rise) begin
          state_n     = MEAS_HIGH;
          period_n    = cnt;
          high_n      = high_tmp;
          cnt_n       = 32'd1;
          set_valid   = 1'b1;
          set_overrun = valid;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= 32'd0;
      period   <= 32'd0;
      high     <= 32'd0;
      high_tmp <= 32'd0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      period   <= period_n;
      high     <= high_n;
      high_tmp <= high_tmp_n;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en      <= 1'b0;
      pol     <= 1'b0;
      irq_en  <= 1'b0;
      valid   <= 1'b0;
      overrun <= 1'b0;
      timeout <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        en     <= i_wdata[CTRL_EN];
        pol    <= i_wdata[CTRL_POL];
        irq_en <= i_wdata[CTRL_IRQ_EN];
      end
      // Hardware set wins over a same-cycle W1C.
      valid   <= (valid   & ~(status_wr & i_wdata[ST_VALID]))   | set_valid;
      overrun <= (overrun & ~(status_wr & i_wdata[ST_OVERRUN])) | set_overrun;
      timeout <= (timeout & ~(status_wr & i_wdata[ST_TIMEOUT])) | set_timeout;
    end
  end

  assign irq = irq_en & (valid | timeout);

  always_comb begin
    o_rdata = 32'd0;
    if (i_sel && !i_we) begin
      unique case (i_addr)
        ADDR_CTRL:   o_rdata = {29'd0, irq_en, pol, en};
        ADDR_PERIOD: o_rdata = period;
        ADDR_HIGH:   o_rdata = high;
        ADDR_STATUS: o_rdata = {cnt[15:0], 12'd0, lvl, timeout, overrun, valid};
        default:     o_rdata = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_capture_ip.sv
// Directed bench for pwm_capture_ip: timestamp-based reference model checked
// every cycle, plus literal expectations at the key points of each scenario.
module tb_pwm_capture_ip;

  localparam int TO     = 1000;
  localparam int PW_PER = 100;
  localparam int PW_HI  = 25;

  logic        clk = 1'b0, reset = 1'b0, i_sel = 1'b0, i_we = 1'b0, pwm_in = 1'b0;
  logic [3:0]  i_addr = 4'h0;
  logic [31:0] i_wdata = 32'd0;
  logic [31:0] o_rdata;
  logic        irq;
  int checks = 0, failures = 0;

  pwm_capture_ip #(.TIMEOUT_CYCLES(32'(TO))) dut (
    .clk(clk), .reset(reset), .i_sel(i_sel), .i_we(i_we), .i_addr(i_addr),
    .i_wdata(i_wdata), .o_rdata(o_rdata), .pwm_in(pwm_in), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: measurement described by edge timestamps.
  bit        m_en, m_pol, m_ie, m_v, m_o, m_t, m_on;
  bit [31:0] m_period, m_high;
  bit        p1, p2, p3;
  int        n, t_arm, t_rise, t_fall;

  function automatic int cnt_at(input int e);
    if (!m_on) return 0;
    if (t_rise < 0) return e - t_arm;
    return e - t_rise + 1;
  endfunction

  function automatic logic [31:0] mread(input logic [3:0] a);
    bit [31:0] c;
    c = 32'(cnt_at(n));
    case (a)
      4'h0:    return {29'd0, m_ie, m_pol, m_en};
      4'h4:    return m_period;
      4'h8:    return m_high;
      4'hC:    return {c[15:0], 12'd0, p2 ^ m_pol, m_t, m_o, m_v};
      default: return 32'd0;
    endcase
  endfunction

  task automatic mreset();
    {m_en, m_pol, m_ie, m_v, m_o, m_t, m_on} = '0;
    m_period = 0; m_high = 0;
    {p1, p2, p3} = '0;
    n = 0; t_arm = 0; t_rise = -1; t_fall = -1;
  endtask

  task automatic mstep();
    bit lvl, lvl_d, rise, fall, cw, sw, en_eff, sv, so, st;
    int c;
    n++;
    c = cnt_at(n - 1);
    lvl = p2 ^ m_pol; lvl_d = p3 ^ m_pol;
    rise = lvl & ~lvl_d; fall = ~lvl & lvl_d;
    cw = i_sel && i_we && (i_addr == 4'h0);
    sw = i_sel && i_we && (i_addr == 4'hC);
    en_eff = cw ? i_wdata[0] : m_en;
    sv = 0; so = 0; st = 0;
    if (!en_eff) m_on = 0;
    else if (!m_on || (cw && (i_wdata[1] != m_pol))) begin
      m_on = 1; t_arm = n; t_rise = -1;
    end else if (c == TO) begin
      st = 1; t_arm = n; t_rise = -1;
    end else if (t_rise < 0) begin
      if (rise) begin t_rise = n; t_fall = -1; end
    end else if (t_fall < t_rise) begin
      if (fall) t_fall = n;
    end else if (rise) begin
      m_period = 32'(n - t_rise);
      m_high = 32'(t_fall - t_rise);
      sv = 1; so = m_v; t_rise = n;
    end
    m_v = (m_v & ~(sw & i_wdata[0])) | sv;
    m_o = (m_o & ~(sw & i_wdata[1])) | so;
    m_t = (m_t & ~(sw & i_wdata[2])) | st;
    if (cw) {m_ie, m_pol, m_en} = i_wdata[2:0];
    p3 = p2; p2 = p1; p1 = pwm_in;
  endtask

  // Model advances and outputs are compared once per cycle, on the falling edge.
  initial forever begin
    @(negedge clk);
    if (reset) mreset(); else mstep();
    if (i_sel && !i_we) check("rdata", o_rdata, mread(i_addr));
    else check("rdata_idle", o_rdata, 32'd0);
    check("irq", {31'd0, irq}, {31'd0, m_ie & (m_v | m_t)});
  end

  bit pw_run = 0;
  int ph = 0;
  initial forever begin
    @(negedge clk);
    #2;
    if (pw_run) begin
      pwm_in = (ph < PW_HI);
      ph = (ph + 1) % PW_PER;
    end else begin
      pwm_in = 1'b0;
      ph = 0;
    end
  end

  task automatic tick(input int k);
    repeat (k) begin @(negedge clk); #1; end
  endtask

  task automatic idle_bus();
    i_sel = 1'b1; i_we = 1'b0; i_addr = 4'hC; i_wdata = 32'd0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    i_sel = 1'b1; i_we = 1'b1; i_addr = a; i_wdata = d;
    tick(1);
    idle_bus();
  endtask

  task automatic expect_reg(input string nm, input logic [3:0] a, input logic [31:0] mask,
                            input logic [31:0] exp);
    logic [31:0] d;
    i_sel = 1'b1; i_we = 1'b0; i_addr = a;
    #1;
    d = o_rdata & mask;
    check(nm, d, exp);
    i_addr = 4'hC;
  endtask

  task automatic wait_rise();
    for (int i = 0; i < 300; i++) begin
      if ((p2 ^ m_pol) & ~(p3 ^ m_pol)) return;
      tick(1);
    end
    checks++; failures++;
    $display("FAIL wait_rise: got no edge expected edge within 300 cycles");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 reset = 1'b1;
    #1;
    check("reset_irq", {31'd0, irq}, 32'd0);
    check("reset_rdata", o_rdata, 32'd0);
    tick(2);
    reset = 1'b0;
    idle_bus();
    tick(2);
    expect_reg("rst_ctrl", 4'h0, '1, 32'd0);
    expect_reg("rst_period", 4'h4, '1, 32'd0);
    expect_reg("rst_high", 4'h8, '1, 32'd0);
    tick(1);
    expect_reg("rst_status", 4'hC, '1, 32'd0);

    // Unused CTRL bits, RO and unmapped offsets
    wr(4'h0, 32'hFFFF_FFF8);
    expect_reg("ctrl_upper", 4'h0, '1, 32'd0);
    wr(4'h8, 32'hDEAD_BEEF);
    expect_reg("high_ro", 4'h8, '1, 32'd0);
    expect_reg("unmapped", 4'h6, '1, 32'd0);
    tick(1);

    // Basic capture, POL=0
    wr(4'h0, 32'd1);
    tick(3);
    expect_reg("arm_cnt", 4'hC, '1, 32'h0003_0000);
    pw_run = 1'b1;
    tick(350);
    expect_reg("period_100", 4'h4, '1, 32'd100);
    expect_reg("high_25", 4'h8, '1, 32'd25);
    expect_reg("valid_ovr", 4'hC, 32'h3, 32'h3);
    tick(1);

    // W1C clear, then W1C colliding with a completing rise
    wr(4'hC, 32'h3);
    expect_reg("w1c_clear", 4'hC, 32'h3, 32'h0);
    wait_rise();
    wr(4'hC, 32'h1);
    expect_reg("set_wins", 4'hC, 32'h3, 32'h1);
    tick(105);
    expect_reg("overrun", 4'hC, 32'h3, 32'h3);
    expect_reg("period_again", 4'h4, '1, 32'd100);
    tick(1);

    // Disable in the middle of the high phase
    wait_rise();
    tick(10);
    wr(4'h0, 32'd0);
    expect_reg("dis_cnt", 4'hC, 32'hFFFF_0000, 32'd0);
    expect_reg("dis_period", 4'h4, '1, 32'd100);
    expect_reg("dis_high", 4'h8, '1, 32'd25);
    tick(5);
    expect_reg("dis_cnt_hold", 4'hC, 32'hFFFF_0000, 32'd0);
    tick(1);

    // Inverted polarity
    wr(4'hC, 32'h7);
    wr(4'h0, 32'd2);
    tick(3);
    wr(4'h0, 32'd3);
    tick(350);
    expect_reg("pol_period", 4'h4, '1, 32'd100);
    expect_reg("pol_high", 4'h8, '1, 32'd75);
    expect_reg("pol_valid", 4'hC, 32'h1, 32'h1);
    tick(1);

    // Timeout with the pin held low
    pw_run = 1'b0;
    wr(4'h0, 32'd0);
    wr(4'hC, 32'h7);
    tick(5);
    wr(4'h0, 32'd5);
    tick(TO);
    expect_reg("pre_timeout", 4'hC, '1, 32'h03E8_0000);
    check("pre_timeout_irq", {31'd0, irq}, 32'd0);
    tick(1);
    expect_reg("timeout", 4'hC, '1, 32'h0000_0004);
    check("timeout_irq", {31'd0, irq}, 32'd1);
    tick(1);
    expect_reg("to_period", 4'h4, '1, 32'd100);
    expect_reg("to_high", 4'h8, '1, 32'd75);
    tick(1);

    // Reset in the middle of the low phase
    wr(4'hC, 32'h7);
    wr(4'h0, 32'd5);
    pw_run = 1'b1;
    tick(250);
    wait_rise();
    tick(50);
    i_sel = 1'b0;
    reset = 1'b1;
    #1;
    check("rst_mid_irq", {31'd0, irq}, 32'd0);
    check("rst_mid_rdata", o_rdata, 32'd0);
    expect_reg("rst_mid_period", 4'h4, '1, 32'd0);
    expect_reg("rst_mid_status", 4'hC, '1, 32'd0);
    tick(2);
    reset = 1'b0;
    idle_bus();
    tick(2);
    expect_reg("post_rst_ctrl", 4'h0, '1, 32'd0);
    expect_reg("post_rst_high", 4'h8, '1, 32'd0);
    tick(1);
    wr(4'h0, 32'd1);
    tick(250);
    expect_reg("rerun_period", 4'h4, '1, 32'd100);
    expect_reg("rerun_high", 4'h8, '1, 32'd25);
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pwm_capture_ip.md
PWM_CAPTURE_IP -- requirements
Module: pwm_capture_ip

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 32'd1_000_000: number of clk cycles without a qualifying edge that aborts a measurement; legal range 2..2^32-1.
REQ-002 SHALL have port clk, input, 1: single clock for all logic.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port i_sel, input, 1: chip select.
REQ-005 SHALL have port i_we, input, 1: write enable.
REQ-006 SHALL have port i_addr, input, 4: byte offset. CTRL=0x0, PERIOD=0x4, HIGH=0x8, STATUS=0xC.
REQ-007 SHALL have port i_wdata, input, 32: write data.
REQ-008 SHALL have port o_rdata, output, 32: read data, combinational.
REQ-009 SHALL have port pwm_in, input, 1: external PWM signal, asynchronous to clk.
REQ-010 SHALL have port irq, output, 1: level interrupt.

Function
REQ-011 Registers: CTRL is RW, with bit0 EN, bit1 POL (invert input) and bit2 IRQ_EN; other CTRL bits SHALL read 0. PERIOD and HIGH are RO. STATUS bits are bit0 VALID, bit1 OVERRUN, bit2 TIMEOUT (each W1C), bit3 LEVEL (RO, synchronized level after POL) and bits[31:16] cnt[15:0] (RO).
REQ-012 Register write: occurs on the clk edge where i_sel=1 and i_we=1. Writes to RO fields or to unmapped offsets SHALL be ignored.
REQ-013 Register read: o_rdata = selected register when i_sel=1 and i_we=0, else 32'b0. Unmapped offsets SHALL read 0.
REQ-014 Synchronizer: pwm_in passes a 2-flop synchronizer. The result is XORed with POL to give lvl. lvl is registered into lvl_d. rise = lvl & ~lvl_d; fall = ~lvl & lvl_d.
REQ-015 Edge latency: an edge on pwm_in SHALL set rise/fall 2-3 clk after the pin edge.
REQ-016 FSM states: IDLE, ARM, MEAS_HIGH, MEAS_LOW.
REQ-017 FSM when EN=0: the state SHALL be IDLE from any state, with cnt=0. PERIOD, HIGH and STATUS flags SHALL be retained.
REQ-018 IDLE -> ARM when EN=1, with cnt <= 0.
REQ-019 ARM -> MEAS_HIGH on rise, with cnt <= 1.
REQ-020 MEAS_HIGH -> MEAS_LOW on fall, with high_tmp <= cnt.
REQ-021 MEAS_LOW -> MEAS_HIGH on rise. On that edge: PERIOD <= cnt, HIGH <= high_tmp, cnt <= 1, VALID <= 1. OVERRUN <= 1 if VALID was already 1.
REQ-022 cnt SHALL increment by 1 every cycle in ARM, MEAS_HIGH and MEAS_LOW, except on the cycles defined above.
REQ-023 Result: PERIOD equals the clk-cycle distance between two consecutive detected rises. HIGH equals the distance from a rise to the following fall.
REQ-024 Timeout: in any non-IDLE state, cnt == TIMEOUT_CYCLES SHALL set TIMEOUT=1 and force ARM with cnt <= 0. PERIOD and HIGH SHALL be unchanged.
REQ-025 Simultaneous W1C and hardware set of the same flag: set SHALL win.
REQ-026 A CTRL write with EN=0 SHALL take effect the next cycle: state IDLE.
REQ-027 A CTRL write that changes POL while EN=1 SHALL abort the measurement: ARM, cnt=0.
REQ-028 irq = IRQ_EN & (VALID | TIMEOUT), derived from registers only, with no combinational path from the bus.

Reset
REQ-029 On reset=1, asynchronously: CTRL=0, PERIOD=0, HIGH=0, high_tmp=0, cnt=0, all STATUS flags=0, synchronizer and lvl_d=0, state=IDLE.
REQ-030 While reset=1, outputs SHALL be irq=0 and o_rdata=0 (with i_sel=0).
REQ-031 Reset asserted mid-measurement SHALL discard the measurement. The first result after reset SHALL need two fresh rises.

Structure
REQ-032 Package pwm_capture_pkg SHALL hold the register offsets, CTRL/STATUS bit indices and the FSM state encoding.
REQ-033 Sub-module pwm_in_sync SHALL hold the 2-flop synchronizer, POL XOR, lvl_d register and rise/fall outputs.
REQ-034 The FSM, counter, registers and bus decode SHALL be in pwm_capture_ip.

Verification
REQ-035 EN=1, pwm_in period 100 clk and high 25 clk, three cycles -> PERIOD=100, HIGH=25, VALID=1 after the 2nd detected rise; STATUS[31:16] cycles 1..100.
REQ-036 Same stimulus with POL=1 -> PERIOD=100, HIGH=75.
REQ-037 Two results without clearing VALID -> OVERRUN=1. Write STATUS=0x3 -> VALID=0, OVERRUN=0. W1C on the same cycle as a new rise -> VALID stays 1.
REQ-038 TIMEOUT_CYCLES=1000, EN=1, pwm_in held 0 -> TIMEOUT=1 exactly 1000 cycles after ARM entry. With IRQ_EN=1, irq=1; PERIOD and HIGH unchanged.
REQ-039 Reset pulse asserted mid-MEAS_LOW -> all registers 0 and state IDLE with no clk edge; re-enable and 2 rises give correct PERIOD.
REQ-040 EN cleared mid-MEAS_HIGH -> cnt=0 and state IDLE next cycle; prior PERIOD=100 and HIGH=25 retained and readable.
